jtdsp16_cache_ctrl: RTL and testbench

Instruction-cache sequencer for the `do K {…}` / `redo K` loop instructions. While the loop body executes for the first time it captures up to 15 single-word instructions as they are fetched from program memory. It then replays them K−1 times from its own storage while holding the program counter. It sits between the ROM data bus and the instruction decoder in the control unit, and drives the cache/ROM instruction-source select and a PC-halt request toward the XAAU.

---
 rtl/jtdsp16_cache_pkg.sv | 19 +
 rtl/jtdsp16_cache_mem.sv | 25 ++
 rtl/jtdsp16_cache_ctrl.sv | 124 ++++++++++++
 tb/tb_jtdsp16_cache_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_cache_pkg.sv
// Shared definitions for the do/redo instruction cache sequencer:
// state encodings, cache geometry and a small index helper.
package jtdsp16_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LOOP = 2'd2
  } state_t;

  localparam int CACHE_DEPTH = 15;
  localparam int AW          = 4;

  // Index of the final body word for a body of length n (n >= 1).
  function automatic logic [AW-1:0] last_idx(input logic [AW-1:0] n);
    return n - 4'd1;
  endfunction

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// Loop-body storage: 16 words, one synchronous write port gated by cen,
// one asynchronous read port feeding the decoder mux.
module jtdsp16_cache_mem
  import jtdsp16_cache_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (cen && we) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/jtdsp16_cache_ctrl.sv
// do/redo loop sequencer: captures the body from ROM on the first pass,
// then replays it from the cache while holding the PC.
module jtdsp16_cache_ctrl
  import jtdsp16_cache_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          do_start,
  input  logic          redo,
  input  logic [3:0]    ni,
  input  logic [6:0]    k,
  input  logic [DW-1:0] rom_dout,
  output logic [DW-1:0] cache_dout,
  output logic          cache_sel,
  output logic          pc_halt,
  output logic          busy,
  output logic          loop_end
);

  state_t          r_state, w_next;
  logic [AW-1:0]   r_wr, r_rd, r_ni;
  logic [6:0]      r_iter;
  logic            r_valid;

  logic            w_last_wr, w_last_rd;
  logic            w_do_ok, w_redo_ok;
  logic            w_we;
  logic [DW-1:0]   w_rd_data;

  assign w_last_wr = (r_wr == last_idx(r_ni));
  assign w_last_rd = (r_rd == last_idx(r_ni));
  assign w_do_ok   = do_start && !redo && (ni != 4'd0) && (int'(ni) <= DEPTH);
  assign w_redo_ok = do_start &&  redo && r_valid && (k != 7'd0);
  assign w_we      = (r_state == ST_FILL);

  jtdsp16_cache_mem #(.DW(DW)) u_mem (
    .clk     (clk),
    .cen     (cen),
    .we      (w_we),
    .wr_addr (r_wr),
    .wr_data (rom_dout),
    .rd_addr (r_rd),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst)      r_state <= ST_IDLE;
    else if (cen) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_do_ok)        w_next = ST_FILL;
        else if (w_redo_ok) w_next = ST_LOOP;
      end
      ST_FILL: begin
        if (w_last_wr) w_next = (r_iter <= 7'd1) ? ST_IDLE : ST_LOOP;
      end
      ST_LOOP: begin
        if (w_last_rd && r_iter == 7'd1) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The fill pass counts as the first iteration, so iter drops by one on entry to LOOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_ni    <= '0;
      r_iter  <= '0;
      r_valid <= 1'b0;
    end else if (cen) begin
      case (r_state)
        ST_IDLE: begin
          if (w_do_ok) begin
            r_ni    <= ni;
            r_iter  <= k;
            r_wr    <= '0;
            r_valid <= 1'b0;
          end else if (w_redo_ok) begin
            r_iter <= k;
            r_rd   <= '0;
          end
        end
        ST_FILL: begin
          if (w_last_wr) begin
            r_valid <= 1'b1;
            r_rd    <= '0;
            if (r_iter > 7'd1) r_iter <= r_iter - 7'd1;
          end else begin
            r_wr <= r_wr + 4'd1;
          end
        end
        ST_LOOP: begin
          if (w_last_rd) begin
            r_rd   <= '0;
            r_iter <= r_iter - 7'd1;
          end else begin
            r_rd <= r_rd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cache_sel = (r_state == ST_LOOP);
    pc_halt   = (r_state == ST_LOOP);
    busy      = (r_state != ST_IDLE);
    loop_end  = (r_state == ST_LOOP) && w_last_rd && (r_iter == 7'd1);
  end

  assign cache_dout = cache_sel ? w_rd_data : '0;

endmodule

// File: tb/tb_jtdsp16_cache_ctrl.sv
// Directed bench for the do/redo cache sequencer: a vector table for the
// basic do loop plus hand-written sequences for the multi-cycle corners.
module tb_jtdsp16_cache_ctrl;

  typedef struct {
    logic        cen;
    logic        ds;
    logic        rdo;
    logic [3:0]  ni;
    logic [6:0]  k;
    logic [15:0] rom;
    logic        sel;
    logic        halt;
    logic        busy;
    logic        lend;
    logic [15:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        do_start;
  logic        redo;
  logic [3:0]  ni;
  logic [6:0]  k;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        cache_sel;
  logic        pc_halt;
  logic        busy;
  logic        loop_end;

  int n_chk = 0;
  int n_err = 0;

  vec_t tbl [14];

  jtdsp16_cache_ctrl #(.DEPTH(15), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .redo       (redo),
    .ni         (ni),
    .k          (k),
    .rom_dout   (rom_dout),
    .cache_dout (cache_dout),
    .cache_sel  (cache_sel),
    .pc_halt    (pc_halt),
    .busy       (busy),
    .loop_end   (loop_end)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic es, input logic eh,
                       input logic eb, input logic el, input logic [15:0] ed);
    logic [19:0] act, exp;
    act = {cache_sel, pc_halt, busy, loop_end, cache_dout};
    exp = {es, eh, eb, el, ed};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: sel/halt/busy/lend/dout got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
               name, cache_sel, pc_halt, busy, loop_end, cache_dout, es, eh, eb, el, ed);
    end
  endtask

  // Drive one slot's inputs, check the outputs presented in that slot, then advance.
  task automatic slot(input logic c, input logic ds, input logic rdo,
                      input logic [3:0] n, input logic [6:0] kk, input logic [15:0] rom,
                      input string name, input logic es, input logic eh,
                      input logic eb, input logic el, input logic [15:0] ed);
    cen = c; do_start = ds; redo = rdo; ni = n; k = kk; rom_dout = rom;
    check(name, es, eh, eb, el, ed);
    tick();
  endtask

  task automatic replay(input int n, input int passes, input logic [15:0] base, input string name);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++)
        slot(1, 0, 0, 0, 0, 16'h0, name, 1, 1, 1,
             (p == passes - 1) && (i == n - 1), base + 16'(i));
  endtask

  task automatic run_do(input int n, input int kk, input logic [15:0] base, input string name);
    slot(1, 1, 0, 4'(n), 7'(kk), 16'h0, {name, "_start"}, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < n; i++)
      slot(1, 0, 0, 0, 0, base + 16'(i), {name, "_fill"}, 0, 0, 1, 0, 16'h0);
    if (kk >= 2) replay(n, kk - 1, base, {name, "_loop"});
    check({name, "_done"}, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic run_redo(input int n, input int kk, input logic [15:0] base, input string name);
    slot(1, 1, 1, 0, 7'(kk), 16'h0, {name, "_start"}, 0, 0, 0, 0, 16'h0);
    replay(n, kk, base, {name, "_loop"});
    check({name, "_done"}, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    logic [15:0] abc [3];
    int idx;
    int cyc;
    logic c;

    abc[0] = 16'h1111; abc[1] = 16'h2222; abc[2] = 16'h3333;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd3, 7'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    for (int i = 0; i < 3; i++)
      tbl[1+i] = '{1'b1, 1'b0, 1'b0, 4'd0, 7'd0, abc[i], 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    for (int i = 0; i < 9; i++)
      tbl[4+i] = '{1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 16'h0, 1'b1, 1'b1, 1'b1,
                   (i == 8), abc[i%3]};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};

    rst = 1'b1; cen = 1'b1; do_start = 1'b0; redo = 1'b0;
    ni = 4'd0; k = 7'd0; rom_dout = 16'h0;
    tick(); tick();
    rst = 1'b0;
    check("reset", 0, 0, 0, 0, 16'h0);

    // redo with no captured body is dropped
    slot(1, 1, 1, 0, 7'd3, 16'h0, "redo_cold_start", 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++)
      slot(1, 0, 0, 0, 0, 16'h0, "redo_cold_idle", 0, 0, 0, 0, 16'h0);

    for (int i = 0; i < 14; i++)
      slot(tbl[i].cen, tbl[i].ds, tbl[i].rdo, tbl[i].ni, tbl[i].k, tbl[i].rom,
           $sformatf("tbl%0d", i), tbl[i].sel, tbl[i].halt, tbl[i].busy,
           tbl[i].lend, tbl[i].dout);

    run_do(2, 1, 16'h5000, "do2_k1");
    run_redo(2, 2, 16'h5000, "redo2_k2");

    slot(1, 1, 0, 4'd0, 7'd5, 16'h0, "do_ni0", 0, 0, 0, 0, 16'h0);
    check("do_ni0_ignored", 0, 0, 0, 0, 16'h0);
    slot(1, 1, 1, 4'd0, 7'd0, 16'h0, "redo_k0", 0, 0, 0, 0, 16'h0);
    check("redo_k0_ignored", 0, 0, 0, 0, 16'h0);
    run_redo(2, 1, 16'h5000, "redo2_k1");

    run_do(15, 127, 16'hA000, "do15_k127");

    // Replay with cen alternating 1,0,1,0: words advance only on cen=1 slots
    run_do(3, 1, 16'h7000, "cen_fill");
    slot(1, 1, 1, 0, 7'd2, 16'h0, "cen_redo", 0, 0, 0, 0, 16'h0);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      c = (cyc % 2 == 0);
      slot(c, 0, 0, 0, 0, 16'h0, "cen_toggle", 1, 1, 1, idx == 5,
           16'h7000 + 16'(idx % 3));
      if (c) idx++;
      cyc++;
    end
    cen = 1'b1;
    check("cen_toggle_done", 0, 0, 0, 0, 16'h0);

    // Reset during the fifth replayed slot clears the captured body
    slot(1, 1, 0, 4'd3, 7'd4, 16'h0, "rst_start", 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++)
      slot(1, 0, 0, 0, 0, abc[i], "rst_fill", 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++)
      slot(1, 0, 0, 0, 0, 16'h0, "rst_loop", 1, 1, 1, 0, abc[i%3]);
    rst = 1'b1;
    slot(1, 0, 0, 0, 0, 16'h0, "rst_loop5", 1, 1, 1, 0, abc[1]);
    rst = 1'b0;
    check("rst_cleared", 0, 0, 0, 0, 16'h0);
    slot(1, 1, 1, 0, 7'd2, 16'h0, "rst_redo", 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++)
      slot(1, 0, 0, 0, 0, 16'h0, "rst_redo_ignored", 0, 0, 0, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
